// File: rtl/zigzag_buf.sv
// rtl/zigzag_buf.sv - ping-pong 8x8 row buffer emitting coefficients in JPEG zigzag order
module zigzag_buf #(
    parameter int QW = 15
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [8*QW-1:0] d,
    input  logic [2:0]      d_cnt,
    input  logic            d_valid,
    output logic            d_hold,
    output logic [QW-1:0]   q,
    output logic [5:0]      q_idx,
    output logic            q_last,
    output logic            q_valid,
    input  logic            q_hold
);

    // Zigzag transfer index -> raster index (row*8+col) within a block.
    localparam logic [5:0] ZZ [0:63] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    logic [QW-1:0] mem [0:127];
    logic [1:0]    wr_ptr;
    logic [1:0]    rd_ptr;
    logic [1:0]    wr_ptr_nxt;
    logic [1:0]    rd_ptr_nxt;
    logic          accept;
    logic          blk_done;
    logic          xfer;
    logic          rd_done;
    logic          load_first;
    logic          load_next;
    logic          rd_bank;
    logic [5:0]    next_idx;
    logic [6:0]    rd_addr;

    assign d_hold     = (wr_ptr[1] != rd_ptr[1]) && (wr_ptr[0] == rd_ptr[0]);
    assign accept     = d_valid & ~d_hold;
    assign blk_done   = accept && (d_cnt == 3'd7);
    assign xfer       = q_valid & ~q_hold;
    assign rd_done    = xfer && (q_idx == 6'd63);
    assign wr_ptr_nxt = wr_ptr + {1'b0, blk_done};
    assign rd_ptr_nxt = rd_ptr + {1'b0, rd_done};

    // A new block starts from the post-edge pointers so a block completing or
    // a bank freeing in this very cycle is seen without a bubble.
    always_comb begin
        load_next  = xfer && !rd_done;
        load_first = (!q_valid || rd_done) && (rd_ptr_nxt != wr_ptr_nxt);
        next_idx   = q_idx + 6'd1;
        rd_bank    = rd_ptr[0];
        if (load_first) begin
            next_idx = 6'd0;
            rd_bank  = rd_ptr_nxt[0];
        end
        rd_addr = {rd_bank, ZZ[next_idx]};
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int j = 0; j < 8; j++) begin
                mem[{wr_ptr[0], d_cnt, 3'(j)}] <= d[j*QW +: QW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr  <= 2'd0;
            rd_ptr  <= 2'd0;
            q       <= '0;
            q_idx   <= 6'd0;
            q_last  <= 1'b0;
            q_valid <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            if (load_first || load_next) begin
                q       <= mem[rd_addr];
                q_idx   <= next_idx;
                q_last  <= (next_idx == 6'd63);
                q_valid <= 1'b1;
            end else if (rd_done) begin
                q_idx   <= 6'd0;
                q_last  <= 1'b0;
                q_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_zigzag_buf.sv
// tb/tb_zigzag_buf.sv - randomized self-checking bench for zigzag_buf against a queue model
module tb_zigzag_buf;
    localparam int QW = 15;

    logic            clk = 1'b0;
    logic            resetn;
    logic [8*QW-1:0] d;
    logic [2:0]      d_cnt;
    logic            d_valid;
    logic            d_hold;
    logic [QW-1:0]   q;
    logic [5:0]      q_idx;
    logic            q_last;
    logic            q_valid;
    logic            q_hold;

    always #5 clk = ~clk;

    zigzag_buf #(.QW(QW)) dut (
        .clk(clk), .resetn(resetn), .d(d), .d_cnt(d_cnt), .d_valid(d_valid),
        .d_hold(d_hold), .q(q), .q_idx(q_idx), .q_last(q_last), .q_valid(q_valid),
        .q_hold(q_hold)
    );

    typedef struct {
        logic [QW-1:0] v;
        int            idx;
    } exp_t;

    exp_t          exp_q[$];
    int            zz[64];
    logic [QW-1:0] part[64];
    logic [QW-1:0] blk[64];
    int            n_chk = 0;
    int            n_fail = 0;
    int            cyc = 0;
    int            nval, first_v, last_v;
    bit            seen_v, hold_seen, last_acc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Zigzag walk over anti-diagonals: odd diagonals go down-left, even go up-right.
    function automatic void build_zz();
        int k = 0;
        for (int s = 0; s < 15; s++) begin
            int lo = (s > 7) ? s - 7 : 0;
            int hi = (s < 7) ? s : 7;
            if (s % 2 == 1) begin
                for (int r = lo; r <= hi; r++) begin zz[k] = r*8 + (s-r); k++; end
            end else begin
                for (int r = hi; r >= lo; r--) begin zz[k] = r*8 + (s-r); k++; end
            end
        end
    endfunction

    function automatic bit exp_hold();
        return ((exp_q.size() + 63) / 64) == 2;
    endfunction

    task automatic tick();
        bit acc, xf;
        acc = resetn && d_valid && !exp_hold();
        xf  = resetn && (exp_q.size() > 0) && !q_hold;
        last_acc = acc;
        if (!resetn) begin
            exp_q.delete();
        end else begin
            if (xf) void'(exp_q.pop_front());
            if (acc) begin
                for (int j = 0; j < 8; j++) part[int'(d_cnt)*8 + j] = d[j*QW +: QW];
                if (d_cnt == 3'd7)
                    for (int k = 0; k < 64; k++) exp_q.push_back('{part[zz[k]], k});
            end
        end
        @(negedge clk);
        cyc++;
        check("q_valid", q_valid, exp_q.size() > 0);
        check("d_hold", d_hold, exp_hold());
        if (d_hold) hold_seen = 1;
        if (q_valid) begin
            if (!seen_v) first_v = cyc;
            seen_v = 1;
            last_v = cyc;
            nval++;
        end
        if (exp_q.size() > 0) begin
            check("q", q, exp_q[0].v);
            check("q_idx", q_idx, exp_q[0].idx);
            check("q_last", q_last, exp_q[0].idx == 63);
        end
    endtask

    task automatic fill_blk(input bit pattern);
        for (int i = 0; i < 64; i++) blk[i] = pattern ? QW'(i) : QW'($urandom());
    endtask

    task automatic set_row(input int r);
        d_cnt = 3'(r);
        for (int j = 0; j < 8; j++) d[j*QW +: QW] = blk[r*8 + j];
    endtask

    task automatic send_rows(input int first, input int last, input int pv, input int ph);
        int r = first;
        int g = 0;
        while (r <= last && g < 3000) begin
            set_row(r);
            d_valid = ($urandom_range(99) < pv);
            q_hold  = ($urandom_range(99) < ph);
            tick();
            if (last_acc) r++;
            g++;
        end
        d_valid = 1'b0;
        q_hold  = 1'b0;
        if (r <= last) check("send_timeout", r, last + 1);
    endtask

    task automatic drain(input int ph);
        int g = 0;
        while (exp_q.size() > 0 && g < 5000) begin
            q_hold = ($urandom_range(99) < ph);
            tick();
            g++;
        end
        q_hold = 1'b0;
        check("drain_empty", exp_q.size(), 0);
    endtask

    task automatic wait_idx(input int idx);
        int g = 0;
        while (!(exp_q.size() > 0 && exp_q[0].idx == idx) && g < 500) begin
            tick();
            g++;
        end
        if (g >= 500) check("wait_idx_timeout", g, 0);
    endtask

    task automatic reset_stats();
        nval = 0; seen_v = 0; hold_seen = 0; first_v = 0; last_v = 0;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_q"}, q, 0);
        check({tag, "_q_idx"}, q_idx, 0);
        check({tag, "_q_last"}, q_last, 0);
        check({tag, "_q_valid"}, q_valid, 0);
        check({tag, "_d_hold"}, d_hold, 0);
    endtask

    initial begin
        build_zz();
        resetn = 1'b0; d = '0; d_cnt = 3'd0; d_valid = 1'b0; q_hold = 1'b0;
        reset_stats();
        @(negedge clk);
        tick();
        tick();
        check_zero_outputs("reset");
        resetn = 1'b1;
        tick();

        // single block with raster-valued pattern
        fill_blk(1);
        send_rows(0, 7, 100, 0);
        check("latency_valid", q_valid, 1);
        check("latency_idx", q_idx, 0);
        drain(0);

        // three blocks back-to-back, no downstream stall
        reset_stats();
        for (int b = 0; b < 3; b++) begin
            fill_blk(0);
            send_rows(0, 7, 100, 0);
        end
        drain(0);
        check("b2b_valid_cycles", nval, 192);
        check("b2b_no_bubble", last_v - first_v + 1, 192);
        check("b2b_hold_seen", hold_seen, 1);

        // random backpressure both sides over four blocks
        for (int b = 0; b < 4; b++) begin
            fill_blk(0);
            send_rows(0, 7, 70, 50);
        end
        drain(50);

        // reset mid-output with the second bank full
        for (int b = 0; b < 2; b++) begin
            fill_blk(0);
            send_rows(0, 7, 100, 0);
        end
        wait_idx(20);
        check("full_before_rst", d_hold, 1);
        resetn = 1'b0;
        tick();
        check_zero_outputs("midrst");
        resetn = 1'b1;
        fill_blk(0);
        send_rows(0, 7, 100, 0);
        check("post_rst_idx", q_idx, 0);
        drain(0);

        // extreme signed values at raster 0 and 63
        fill_blk(0);
        blk[0]  = {1'b1, {(QW-1){1'b0}}};
        blk[63] = {1'b0, {(QW-1){1'b1}}};
        send_rows(0, 7, 100, 0);
        check("min_at_0", q, {1'b1, {(QW-1){1'b0}}});
        wait_idx(63);
        check("max_at_63", q, {1'b0, {(QW-1){1'b1}}});
        drain(0);

        // row-7 accept coinciding with the idx-63 transfer
        fill_blk(0);
        send_rows(0, 7, 100, 0);
        fill_blk(0);
        send_rows(0, 6, 100, 0);
        wait_idx(63);
        set_row(7);
        d_valid = 1'b1;
        check("sim_d_hold_pre", d_hold, 0);
        tick();
        d_valid = 1'b0;
        check("sim_accepted", last_acc, 1);
        check("sim_idx0", q_idx, 0);
        check("sim_valid", q_valid, 1);
        check("sim_d_hold_post", d_hold, 0);
        drain(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
